// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the AXI4 initiator blocks:
//   - default bus widths (used as parameter defaults by the initiators)
//   - AxBURST and xRESP encodings
//   - mst_state_e, the initiator transaction state machine encoding
// -----------------------------------------------------------------------------
package axi_pkg;

    // Default widths
    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;
    localparam int AXI_LEN_W  = 4;

    // AxBURST encodings
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // RRESP / BRESP encodings
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Initiator state machine. IDLE must stay at encoding 0: the debug
    // state output reads 0 out of reset.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_WDATA = 3'd4,
        ST_WRESP = 3'd5
    } mst_state_e;

endpackage

// File: rtl/axi_beat_counter.sv
// -----------------------------------------------------------------------------
// axi_beat_counter
// Counts data beats of one burst and flags the final beat.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : restart the count at 0 (asserted when a new burst is accepted)
//   inc       : one beat handshake completed this cycle
//   len       : burst length minus one (AxLEN)
//   count     : beats completed so far in this burst
//   is_last   : the beat currently on the bus is the final one (count == len)
//
// The count saturates at all-ones so that a read slave that keeps sending
// beats past the programmed length (missing RLAST) cannot make it wrap back
// to a value that would look like a legal beat index.
// -----------------------------------------------------------------------------
module axi_beat_counter #(
    parameter int LEN_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                inc,
    input  logic [LEN_BITS-1:0] len,
    output logic [LEN_BITS-1:0] count,
    output logic                is_last
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign is_last = (count == len);

endmodule

// File: rtl/axi_master_port.sv
// -----------------------------------------------------------------------------
// axi_master_port
// AXI4 initiator: converts one core-side request (address, length, size,
// direction) into a single INCR burst on AR/R or AW/W/B. One transaction is
// in flight at a time; completion is reported with a one-cycle DONE pulse and
// an ERR flag (any non-OKAY response, wrong ID, or RLAST out of place).
//
// Handshake semantics (all channels, core side and AXI side): a transfer
// happens on a rising clk edge where VALID and READY are both 1. Once this
// block raises a VALID it keeps it, and the payload, stable until READY.
// The core's WVALID_IN must not depend on WREADY_IN.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   REQ_*                         core request (VALID/READY, WRITE, ADDR, LEN, SIZE)
//   WDATA_IN/WSTRB_IN/WVALID_IN   core write beat, WREADY_IN = beat taken
//   RDATA_OUT/RVALID_OUT/RLAST_OUT core read beat, RREADY_IN = core backpressure
//   DONE / ERR                    end-of-transaction pulse and its error status
//   AR*, R*, AW*, W*, B*          AXI4 master channels
//   dbg_state                     current mst_state_e encoding
// -----------------------------------------------------------------------------
module axi_master_port
    import axi_pkg::*;
#(
    parameter int ID_BITS   = AXI_ID_W,
    parameter int ADDR_BITS = AXI_ADDR_W,
    parameter int DATA_BITS = AXI_DATA_W,
    parameter int STRB_BITS = AXI_STRB_W,
    parameter int LEN_BITS  = AXI_LEN_W,
    parameter int MASTER_ID = 0
) (
    input  logic                 clk,
    input  logic                 rst,

    // Core request port
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic                 REQ_WRITE,
    input  logic [ADDR_BITS-1:0] REQ_ADDR,
    input  logic [LEN_BITS-1:0]  REQ_LEN,
    input  logic [2:0]           REQ_SIZE,

    // Core write data
    input  logic [DATA_BITS-1:0] WDATA_IN,
    input  logic [STRB_BITS-1:0] WSTRB_IN,
    input  logic                 WVALID_IN,
    output logic                 WREADY_IN,

    // Core read data
    output logic [DATA_BITS-1:0] RDATA_OUT,
    output logic                 RVALID_OUT,
    output logic                 RLAST_OUT,
    input  logic                 RREADY_IN,

    // Completion
    output logic                 DONE,
    output logic                 ERR,

    // AXI read address
    output logic [ID_BITS-1:0]   ARID,
    output logic [ADDR_BITS-1:0] ARADDR,
    output logic [LEN_BITS-1:0]  ARLEN,
    output logic [2:0]           ARSIZE,
    output logic [1:0]           ARBURST,
    output logic                 ARVALID,
    input  logic                 ARREADY,

    // AXI read data
    input  logic [ID_BITS-1:0]   RID,
    input  logic [DATA_BITS-1:0] RDATA,
    input  logic [1:0]           RRESP,
    input  logic                 RLAST,
    input  logic                 RVALID,
    output logic                 RREADY,

    // AXI write address
    output logic [ID_BITS-1:0]   AWID,
    output logic [ADDR_BITS-1:0] AWADDR,
    output logic [LEN_BITS-1:0]  AWLEN,
    output logic [2:0]           AWSIZE,
    output logic [1:0]           AWBURST,
    output logic                 AWVALID,
    input  logic                 AWREADY,

    // AXI write data
    output logic [DATA_BITS-1:0] WDATA,
    output logic [STRB_BITS-1:0] WSTRB,
    output logic                 WLAST,
    output logic                 WVALID,
    input  logic                 WREADY,

    // AXI write response
    input  logic [ID_BITS-1:0]   BID,
    input  logic [1:0]           BRESP,
    input  logic                 BVALID,
    output logic                 BREADY,

    // Debug
    output logic [2:0]           dbg_state
);

    localparam logic [ID_BITS-1:0] MID = ID_BITS'(MASTER_ID);

    mst_state_e           state;
    logic [ADDR_BITS-1:0] addr_q;
    logic [LEN_BITS-1:0]  len_q;
    logic [2:0]           size_q;
    logic                 err_flag;
    logic                 done_q;
    logic                 err_q;

    logic                 req_accept;
    logic                 r_hs;
    logic                 w_hs;
    logic                 r_beat_err;
    logic                 b_err;
    logic [LEN_BITS-1:0]  beat_count;
    logic                 beat_last;

    // ------------------------------------------------------------------
    // Beat counter
    // ------------------------------------------------------------------
    axi_beat_counter #(
        .LEN_BITS (LEN_BITS)
    ) u_beat_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (req_accept),
        .inc     (r_hs || w_hs),
        .len     (len_q),
        .count   (beat_count),
        .is_last (beat_last)
    );

    // ------------------------------------------------------------------
    // Core request port. READY is held low during the DONE cycle so the
    // core sees completion before a new transaction can start.
    // ------------------------------------------------------------------
    assign REQ_READY  = (state == ST_IDLE) && !done_q && !rst;
    assign req_accept = REQ_VALID && REQ_READY;

    // ------------------------------------------------------------------
    // Address channels, driven from the latched request. The direction is
    // carried by the state itself, so no separate write bit is kept.
    // ------------------------------------------------------------------
    assign ARID    = MID;
    assign ARADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARSIZE  = size_q;
    assign ARBURST = BURST_INCR;
    assign ARVALID = (state == ST_RADDR);

    assign AWID    = MID;
    assign AWADDR  = addr_q;
    assign AWLEN   = len_q;
    assign AWSIZE  = size_q;
    assign AWBURST = BURST_INCR;
    assign AWVALID = (state == ST_WADDR);

    // ------------------------------------------------------------------
    // Read data: zero-latency pass-through between slave and core
    // ------------------------------------------------------------------
    assign RREADY     = (state == ST_RDATA) && RREADY_IN;
    assign RVALID_OUT = (state == ST_RDATA) && RVALID;
    assign RLAST_OUT  = (state == ST_RDATA) && RLAST;
    assign RDATA_OUT  = RDATA;
    assign r_hs       = RVALID && RREADY;

    // A beat is in error if the response is not OKAY, the ID is foreign,
    // or RLAST does not line up with the programmed length.
    assign r_beat_err = (RRESP != RESP_OKAY) || (RID != MID) || (RLAST != beat_last);

    // ------------------------------------------------------------------
    // Write data: pass-through, WLAST generated from the beat counter
    // ------------------------------------------------------------------
    assign WVALID    = (state == ST_WDATA) && WVALID_IN;
    assign WREADY_IN = (state == ST_WDATA) && WREADY;
    assign WDATA     = WDATA_IN;
    assign WSTRB     = WSTRB_IN;
    assign WLAST     = (state == ST_WDATA) && beat_last;
    assign w_hs      = WVALID && WREADY;

    // ------------------------------------------------------------------
    // Write response
    // ------------------------------------------------------------------
    assign BREADY = (state == ST_WRESP);
    assign b_err  = (BRESP != RESP_OKAY) || (BID != MID);

    // ------------------------------------------------------------------
    // Transaction state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            err_flag <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_accept) begin
                        addr_q   <= REQ_ADDR;
                        len_q    <= REQ_LEN;
                        size_q   <= REQ_SIZE;
                        err_flag <= 1'b0;
                        state    <= REQ_WRITE ? ST_WADDR : ST_RADDR;
                    end
                end
                ST_RADDR: begin
                    if (ARREADY) begin
                        state <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (r_hs) begin
                        err_flag <= err_flag || r_beat_err;
                        // RLAST ends the burst even if it arrives early.
                        if (RLAST) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                            err_q  <= err_flag || r_beat_err;
                        end
                    end
                end
                ST_WADDR: begin
                    if (AWREADY) begin
                        state <= ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (w_hs && beat_last) begin
                        state <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (BVALID) begin
                        err_flag <= err_flag || b_err;
                        state    <= ST_IDLE;
                        done_q   <= 1'b1;
                        err_q    <= err_flag || b_err;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign DONE      = done_q;
    assign ERR       = err_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_axi_master_port.sv
// -----------------------------------------------------------------------------
// tb_axi_master_port
// Self-checking bench for axi_master_port. The bench plays both the core and
// the AXI slave. Inputs change on the falling edge; outputs are sampled 1ns
// later, well clear of the rising edge where the DUT acts. Read and write
// data beats are pushed to exp_q when offered and popped when the handshake
// is seen on the far side.
// -----------------------------------------------------------------------------
module tb_axi_master_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        REQ_VALID, REQ_READY, REQ_WRITE;
    logic [31:0] REQ_ADDR;
    logic [3:0]  REQ_LEN;
    logic [2:0]  REQ_SIZE;
    logic [31:0] WDATA_IN;
    logic [3:0]  WSTRB_IN;
    logic        WVALID_IN, WREADY_IN;
    logic [31:0] RDATA_OUT;
    logic        RVALID_OUT, RLAST_OUT, RREADY_IN;
    logic        DONE, ERR;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID, ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST, RVALID, RREADY;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID, AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST, WVALID, WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID, BREADY;
    logic [2:0]  dbg_state;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    always #5 clk = ~clk;

    axi_master_port dut (
        .clk(clk), .rst(rst),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN), .REQ_SIZE(REQ_SIZE),
        .WDATA_IN(WDATA_IN), .WSTRB_IN(WSTRB_IN), .WVALID_IN(WVALID_IN), .WREADY_IN(WREADY_IN),
        .RDATA_OUT(RDATA_OUT), .RVALID_OUT(RVALID_OUT), .RLAST_OUT(RLAST_OUT), .RREADY_IN(RREADY_IN),
        .DONE(DONE), .ERR(ERR),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .dbg_state(dbg_state)
    );

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic idle_inputs();
        REQ_VALID = 0; REQ_WRITE = 0; REQ_ADDR = '0; REQ_LEN = '0; REQ_SIZE = '0;
        WDATA_IN = '0; WSTRB_IN = '0; WVALID_IN = 0; RREADY_IN = 0;
        ARREADY = 0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 0; RVALID = 0;
        AWREADY = 0; WREADY = 0; BID = '0; BRESP = '0; BVALID = 0;
    endtask

    // Issues a request at a falling edge and leaves the bench at the falling
    // edge right after acceptance (address phase visible).
    task automatic send_req(input string name, input logic wr, input logic [31:0] addr,
                            input logic [3:0] len);
        @(negedge clk);
        REQ_VALID = 1; REQ_WRITE = wr; REQ_ADDR = addr; REQ_LEN = len; REQ_SIZE = 3'd2;
        #1;
        checks++;
        if (REQ_READY !== 1'b1) begin
            errors++; $display("FAIL %s_req_ready: got %b want 1", name, REQ_READY);
        end
        @(negedge clk);
        REQ_VALID = 0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({ARVALID, AWVALID, WVALID, RREADY, BREADY, DONE, ERR, REQ_READY, RVALID_OUT,
             WREADY_IN, dbg_state, ARADDR, ARLEN} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valids=%b%b%b%b%b done=%b err=%b req_ready=%b state=%0d araddr=%h want all 0",
                     ARVALID, AWVALID, WVALID, RREADY, BREADY, DONE, ERR, REQ_READY, dbg_state, ARADDR);
        end
        rst = 0;
        #1;
        checks++;
        if (REQ_READY !== 1'b1) begin
            errors++; $display("FAIL reset_req_ready: got %b want 1", REQ_READY);
        end
    endtask

    task automatic test_read(input string name, input logic [31:0] addr, input logic [3:0] len,
                             input int ar_delay, input int last_beat, input bit toggle);
        logic [31:0] d, exp;
        logic        exp_err;
        int          beats, cyc;
        bit          pending, fin;
        exp_err = (last_beat != int'(len) + 1);
        send_req(name, 1'b0, addr, len);
        // Address phase: ARVALID and fields held for ar_delay cycles, then taken.
        for (int k = 0; k <= ar_delay; k++) begin
            #1;
            checks++;
            if ({ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, ARID} !== {1'b1, addr, len, 3'd2, 2'b01, 4'd0}) begin
                errors++;
                $display("FAIL %s_ar cyc%0d: got v=%b a=%h len=%0d size=%0d burst=%b id=%0d want v=1 a=%h len=%0d size=2 burst=01 id=0",
                         name, k, ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, ARID, addr, len);
            end
            if (k == ar_delay) ARREADY = 1;
            @(negedge clk);
        end
        ARREADY = 0;
        // Data phase
        beats = 0; cyc = 0; pending = 0; fin = 0;
        while (!fin && cyc < 200) begin
            if (!pending) begin
                d = $urandom;
                RDATA = d; RLAST = (beats + 1 == last_beat); RRESP = 2'b00; RID = '0; RVALID = 1;
                exp_q.push_back(d);
                pending = 1;
            end
            RREADY_IN = toggle ? cyc[0] : 1'b1;
            #1;
            checks++;
            if (RREADY !== RREADY_IN || RVALID_OUT !== 1'b1 || DONE !== 1'b0) begin
                errors++;
                $display("FAIL %s_r_pass beat%0d: got rready=%b rvalid_out=%b done=%b want rready=%b rvalid_out=1 done=0",
                         name, beats, RREADY, RVALID_OUT, DONE, RREADY_IN);
            end
            if (RREADY_IN) begin
                exp = exp_q.pop_front();
                checks++;
                if (RDATA_OUT !== exp || RLAST_OUT !== RLAST) begin
                    errors++;
                    $display("FAIL %s_r_beat%0d: got data=%h last=%b want data=%h last=%b",
                             name, beats, RDATA_OUT, RLAST_OUT, exp, RLAST);
                end
                beats++;
                pending = 0;
                if (RLAST) fin = 1;
            end
            @(negedge clk);
            cyc++;
        end
        RVALID = 0; RLAST = 0; RREADY_IN = 0;
        if (!fin) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got %0d beats want %0d", name, beats, last_beat);
        end
        #1;
        checks++;
        if ({DONE, ERR, REQ_READY} !== {1'b1, exp_err, 1'b0}) begin
            errors++;
            $display("FAIL %s_done: got done=%b err=%b req_ready=%b want done=1 err=%b req_ready=0",
                     name, DONE, ERR, REQ_READY, exp_err);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({DONE, REQ_READY, dbg_state} !== {1'b0, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL %s_idle: got done=%b req_ready=%b state=%0d want 0 1 0", name, DONE, REQ_READY, dbg_state);
        end
        exp_q.delete();
    endtask

    task automatic test_write(input string name, input logic [31:0] addr, input logic [3:0] len,
                              input logic [31:0] first_data, input logic [1:0] bresp,
                              input logic [3:0] bid, input bit rand_ready);
        logic [31:0] d, exp;
        logic        exp_err;
        int          beats, cyc;
        bit          pending, fin;
        exp_err = (bresp != 2'b00) || (bid != 4'd0);
        send_req(name, 1'b1, addr, len);
        #1;
        checks++;
        if ({AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID, ARVALID} !== {1'b1, addr, len, 3'd2, 2'b01, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL %s_aw: got v=%b a=%h len=%0d size=%0d burst=%b id=%0d arvalid=%b want v=1 a=%h len=%0d",
                     name, AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID, ARVALID, addr, len);
        end
        AWREADY = 1;
        @(negedge clk);
        AWREADY = 0;
        beats = 0; cyc = 0; pending = 0; fin = 0;
        while (!fin && cyc < 200) begin
            if (!pending) begin
                d = (beats == 0) ? first_data : $urandom;
                WDATA_IN = d; WSTRB_IN = 4'($urandom_range(1, 15)); WVALID_IN = 1;
                exp_q.push_back(d);
                pending = 1;
            end
            WREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            checks++;
            if (WVALID !== 1'b1 || WREADY_IN !== WREADY || WSTRB !== WSTRB_IN || DONE !== 1'b0) begin
                errors++;
                $display("FAIL %s_w_pass beat%0d: got wvalid=%b wready_in=%b wstrb=%h done=%b want 1 %b %h 0",
                         name, beats, WVALID, WREADY_IN, WSTRB, DONE, WREADY, WSTRB_IN);
            end
            if (WREADY) begin
                exp = exp_q.pop_front();
                checks++;
                if (WDATA !== exp || WLAST !== (beats == int'(len))) begin
                    errors++;
                    $display("FAIL %s_w_beat%0d: got data=%h wlast=%b want data=%h wlast=%b",
                             name, beats, WDATA, WLAST, exp, (beats == int'(len)));
                end
                beats++;
                pending = 0;
                if (beats == int'(len) + 1) fin = 1;
            end
            @(negedge clk);
            cyc++;
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got %0d beats want %0d", name, beats, int'(len) + 1);
        end
        // Response phase; an extra core beat is offered and must not pass.
        WVALID_IN = 1; WDATA_IN = 32'hBAD0_BAD0; WREADY = 1;
        #1;
        checks++;
        if ({BREADY, WREADY_IN, WVALID} !== 3'b100) begin
            errors++;
            $display("FAIL %s_b_wait: got bready=%b wready_in=%b wvalid=%b want 1 0 0", name, BREADY, WREADY_IN, WVALID);
        end
        BVALID = 1; BRESP = bresp; BID = bid;
        @(negedge clk);
        BVALID = 0; BRESP = '0; BID = '0; WVALID_IN = 0; WREADY = 0;
        #1;
        checks++;
        if ({DONE, ERR, REQ_READY} !== {1'b1, exp_err, 1'b0}) begin
            errors++;
            $display("FAIL %s_done: got done=%b err=%b req_ready=%b want done=1 err=%b req_ready=0",
                     name, DONE, ERR, REQ_READY, exp_err);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({DONE, REQ_READY, dbg_state} !== {1'b0, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL %s_idle: got done=%b req_ready=%b state=%0d want 0 1 0", name, DONE, REQ_READY, dbg_state);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_write();
        send_req("rst_mid", 1'b1, 32'h0000_3000, 4'd3);
        AWREADY = 1;
        @(negedge clk);
        AWREADY = 0;
        // Two of four beats, both with WLAST low
        for (int b = 0; b < 2; b++) begin
            WDATA_IN = $urandom; WSTRB_IN = 4'hF; WVALID_IN = 1; WREADY = 1;
            #1;
            checks++;
            if ({WVALID, WLAST} !== 2'b10) begin
                errors++; $display("FAIL rst_mid_w%0d: got wvalid=%b wlast=%b want 1 0", b, WVALID, WLAST);
            end
            @(negedge clk);
        end
        rst = 1;
        idle_inputs();
        @(negedge clk);
        #1;
        checks++;
        if ({ARVALID, AWVALID, WVALID, WLAST, RREADY, BREADY, DONE, ERR, REQ_READY, WREADY_IN,
             dbg_state, AWADDR, AWLEN} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got aw=%b w=%b wlast=%b b=%b done=%b req_ready=%b state=%0d awaddr=%h want all 0",
                     AWVALID, WVALID, WLAST, BREADY, DONE, REQ_READY, dbg_state, AWADDR);
        end
        rst = 0;
        #1;
        checks++;
        if (REQ_READY !== 1'b1) begin
            errors++; $display("FAIL rst_mid_req_ready: got %b want 1", REQ_READY);
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_read ("rd_basic",   32'h0000_1000, 4'd3, 0, 4, 1'b0);
        test_write("wr_single",  32'h0000_2000, 4'd0, 32'hDEAD_BEEF, 2'b00, 4'd0, 1'b0);
        test_write("wr_decerr",  32'hF000_0000, 4'd1, 32'h1234_5678, 2'b11, 4'd0, 1'b0);
        test_read ("rd_after",   32'h0000_1100, 4'd0, 0, 1, 1'b0);
        test_read ("rd_slow",    32'h0000_1200, 4'd7, 5, 8, 1'b1);
        test_read ("rd_early",   32'h0000_1300, 4'd3, 0, 2, 1'b0);
        test_read ("rd_nolast",  32'h0000_1400, 4'd1, 1, 3, 1'b0);
        test_write("wr_burst",   32'h0000_2100, 4'd15, 32'hCAFE_0001, 2'b00, 4'd0, 1'b1);
        test_write("wr_badid",   32'h0000_2200, 4'd2, 32'h0BAD_1D00, 2'b00, 4'd5, 1'b1);
        test_write("wr_slverr",  32'h0000_2300, 4'd0, 32'h5A5A_5A5A, 2'b10, 4'd0, 1'b0);
        test_reset_mid_write();
        test_read ("rd_post_rst", 32'h0000_1500, 4'd2, 2, 3, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
